// File: rtl/amiga_vpa_sequencer_if.sv
// Bus bundle between the CPU bus core and the VPA sequencer.
// AMIGA_VPA_AUTOVEC_EN adds the function-code input and the autovector flag.
interface amiga_vpa_sequencer_if;
  logic       as_n_i;
  logic       vpa_n_i;
  logic       e_o;
  logic       vma_n_o;
  logic       cyc_end_o;
  logic       busy_o;
`ifdef AMIGA_VPA_AUTOVEC_EN
  logic [2:0] fc_i;
  logic       autovec_o;

  modport slave (
    input  as_n_i, vpa_n_i, fc_i,
    output e_o, vma_n_o, cyc_end_o, busy_o, autovec_o
  );
  modport master (
    output as_n_i, vpa_n_i, fc_i,
    input  e_o, vma_n_o, cyc_end_o, busy_o, autovec_o
  );
`else
  modport slave (
    input  as_n_i, vpa_n_i,
    output e_o, vma_n_o, cyc_end_o, busy_o
  );
  modport master (
    output as_n_i, vpa_n_i,
    input  e_o, vma_n_o, cyc_end_o, busy_o
  );
`endif
endinterface

// File: rtl/amiga_vpa_sequencer.sv
// 6800-style synchronous peripheral cycle sequencer: free-running E clock, _VMA strobe, CYC_END pulse.
// Optional feature macro: AMIGA_VPA_AUTOVEC_EN (FC capture, autovector IACK cycles).
module amiga_vpa_sequencer #(
  parameter int unsigned E_LOW  = 6,
  parameter int unsigned E_HIGH = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  amiga_vpa_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(E_LOW + E_HIGH - 1);
  localparam logic [CNT_W-1:0] SYNC_CNT = CNT_W'(E_LOW - 2);
  localparam logic [CNT_W-1:0] E_LOW_C  = CNT_W'(E_LOW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    VMA  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d;
  logic             vma_n_q, vma_n_d;
  logic             cyc_end_q, cyc_end_d;
  logic             busy_q, busy_d;
  logic             abort_q, abort_d;
  logic             iack_q, iack_d;
`ifdef AMIGA_VPA_AUTOVEC_EN
  logic             autovec_q, autovec_d;
`endif

  // Phase counter free-runs; E is derived from the next count so both move on the same edge.
  always_comb begin
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (cnt_q == CNT_MAX) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    e_d = (cnt_d >= E_LOW_C);
  end

  // Next-state and registered-output decode for the bus cycle FSM.
  always_comb begin
    state_d   = state_q;
    vma_n_d   = 1'b1;
    cyc_end_d = 1'b0;
    abort_d   = abort_q;
    iack_d    = iack_q;
`ifdef AMIGA_VPA_AUTOVEC_EN
    autovec_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!bus.as_n_i && !bus.vpa_n_i) begin
          state_d = SYNC;
          abort_d = 1'b0;
`ifdef AMIGA_VPA_AUTOVEC_EN
          iack_d  = (bus.fc_i == 3'b111);
`else
          iack_d  = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SYNC: begin
        if (bus.as_n_i) begin
          state_d = IDLE;
        end else if (cnt_q == SYNC_CNT) begin
          state_d = VMA;
          vma_n_d = iack_q;
        end else begin
          state_d = SYNC;
        end
      end
      VMA: begin
        // The peripheral cycle always runs to E fall; an early _AS release only drops CYC_END.
        if (cnt_q == CNT_MAX) begin
          if (abort_q || bus.as_n_i) begin
            state_d = IDLE;
          end else begin
            state_d   = DONE;
            cyc_end_d = 1'b1;
`ifdef AMIGA_VPA_AUTOVEC_EN
            autovec_d = iack_q;
`endif
          end
        end else begin
          vma_n_d = iack_q;
          abort_d = abort_q | bus.as_n_i;
        end
      end
      DONE: begin
        if (bus.as_n_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      e_q       <= 1'b0;
      vma_n_q   <= 1'b1;
      cyc_end_q <= 1'b0;
      busy_q    <= 1'b0;
      abort_q   <= 1'b0;
      iack_q    <= 1'b0;
`ifdef AMIGA_VPA_AUTOVEC_EN
      autovec_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      e_q       <= e_d;
      vma_n_q   <= vma_n_d;
      cyc_end_q <= cyc_end_d;
      busy_q    <= busy_d;
      abort_q   <= abort_d;
      iack_q    <= iack_d;
`ifdef AMIGA_VPA_AUTOVEC_EN
      autovec_q <= autovec_d;
`endif
    end
  end

  assign bus.e_o       = e_q;
  assign bus.vma_n_o   = vma_n_q;
  assign bus.cyc_end_o = cyc_end_q;
  assign bus.busy_o    = busy_q;
`ifdef AMIGA_VPA_AUTOVEC_EN
  assign bus.autovec_o = autovec_q;
`endif

endmodule

// File: tb/tb_amiga_vpa_sequencer.sv
// Directed bench for amiga_vpa_sequencer; tracks the E phase count itself and checks every output per CLK.
module tb_amiga_vpa_sequencer;

  logic clk;
  logic rst;
  int   mcnt;
  int   total;
  int   passed;

  amiga_vpa_sequencer_if bus ();

  amiga_vpa_sequencer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b (phase %0d)", tag, obs, exp, mcnt);
  endtask

  // one CLK edge, then settle; mcnt is the expected phase counter after that edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) mcnt = 0;
    else     mcnt = (mcnt == 9) ? 0 : mcnt + 1;
  endtask

  task automatic chk_all(input string tag, input logic vma_n, input logic cyc, input logic busy);
    chk({tag, "_e"},    bus.e_o,       (mcnt >= 6) ? 1'b1 : 1'b0);
    chk({tag, "_vma"},  bus.vma_n_o,   vma_n);
    chk({tag, "_cyc"},  bus.cyc_end_o, cyc);
    chk({tag, "_busy"}, bus.busy_o,    busy);
`ifdef AMIGA_VPA_AUTOVEC_EN
    if (!cyc) chk({tag, "_av"}, bus.autovec_o, 1'b0);
`endif
  endtask

  task automatic wait_cnt(input int n);
    for (int i = 0; i < 10 && mcnt != n; i++) tick();
  endtask

  task automatic request();
    bus.as_n_i  = 1'b0;
    bus.vpa_n_i = 1'b0;
  endtask

  task automatic release_bus();
    bus.as_n_i  = 1'b1;
    bus.vpa_n_i = 1'b1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    mcnt   = 0;
    rst    = 1'b1;
    release_bus();
`ifdef AMIGA_VPA_AUTOVEC_EN
    bus.fc_i = 3'b110;
`endif
    tick();
    tick();
    chk_all("reset", 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // idle E pattern
    for (int k = 1; k <= 25; k++) begin
      tick();
      chk_all("idle", 1'b1, 1'b0, 1'b0);
    end

    // request at phase 1; _VPA dropped in SYNC; _AS held after DONE is ignored
    wait_cnt(1);
    request();
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk_all("req1", (k >= 4 && k <= 8) ? 1'b0 : 1'b1, (k == 9) ? 1'b1 : 1'b0, 1'b1);
      if (k == 2) bus.vpa_n_i = 1'b1;
      if (k == 9) chk("req1_phase0", bus.e_o, 1'b0);
    end
    release_bus();
    tick();
    chk_all("req1_end", 1'b1, 1'b0, 1'b0);

    // request at phase 4 misses the window, CYC_END 16 CLKs later
    wait_cnt(4);
    request();
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk_all("late", (k >= 11 && k <= 15) ? 1'b0 : 1'b1, (k == 16) ? 1'b1 : 1'b0, 1'b1);
    end
    release_bus();
    tick();
    chk_all("late_end", 1'b1, 1'b0, 1'b0);

    // abort in SYNC
    wait_cnt(2);
    request();
    tick();
    chk_all("sabort_sync", 1'b1, 1'b0, 1'b1);
    release_bus();
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all("sabort", 1'b1, 1'b0, 1'b0);
    end

    // abort in VMA at phase 7
    wait_cnt(1);
    request();
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all("vabort", (k >= 4 && k <= 8) ? 1'b0 : 1'b1, 1'b0, (k <= 8) ? 1'b1 : 1'b0);
      if (k == 6) release_bus();
    end

    // reset during VMA
    wait_cnt(1);
    request();
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_all("prerst", (k >= 4) ? 1'b0 : 1'b1, 1'b0, 1'b1);
    end
    rst = 1'b1;
    release_bus();
    tick();
    chk_all("midrst", 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all("postrst", 1'b1, 1'b0, 1'b0);
    end

`ifdef AMIGA_VPA_AUTOVEC_EN
    // interrupt acknowledge: no _VMA, AUTOVEC with CYC_END
    bus.fc_i = 3'b111;
    wait_cnt(1);
    request();
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all("iack", 1'b1, (k == 9) ? 1'b1 : 1'b0, 1'b1);
      if (k == 1) bus.fc_i = 3'b000;
      if (k == 9) chk("iack_av", bus.autovec_o, 1'b1);
    end
    release_bus();
    tick();
    chk_all("iack_end", 1'b1, 1'b0, 1'b0);

    // ordinary function code: normal cycle, AUTOVEC stays low
    bus.fc_i = 3'b101;
    wait_cnt(1);
    request();
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all("fc5", (k >= 4 && k <= 8) ? 1'b0 : 1'b1, (k == 9) ? 1'b1 : 1'b0, 1'b1);
      if (k == 9) chk("fc5_av", bus.autovec_o, 1'b0);
    end
    release_bus();
    tick();
    chk_all("fc5_end", 1'b1, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
